// File: rtl/abr_prim_subreg_shadow.sv
// Shadowed register slice: a software value commits only after two identical writes.
// The committed copy is mirrored by an inverted shadow copy so storage faults are flagged.
// Hardware update port overrides software; update and storage errors are registered.

package abr_prim_subreg_pkg;
  typedef enum logic [2:0] {
    SwAccessRW  = 3'd0,
    SwAccessW1C = 3'd1,
    SwAccessW1S = 3'd2,
    SwAccessW0C = 3'd3
  } sw_access_e;
endpackage

module abr_prim_subreg_shadow
  import abr_prim_subreg_pkg::*;
#(
  parameter int unsigned      DW       = 32,
  parameter sw_access_e       SwAccess = SwAccessRW,
  parameter logic [DW-1:0]    RESVAL   = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          re,
  input  logic          we,
  input  logic [DW-1:0] wd,
  input  logic          de,
  input  logic [DW-1:0] d,
  output logic          qe,
  output logic [DW-1:0] q,
  output logic [DW-1:0] qs,
  output logic [DW-1:0] ds,
  output logic          phase,
  output logic          err_update,
  output logic          err_storage
);

  // Reject unsupported software access modes at elaboration time.
  if (!(SwAccess inside {SwAccessRW, SwAccessW1C, SwAccessW1S, SwAccessW0C})) begin : g_bad_access
    $error("abr_prim_subreg_shadow: unsupported SwAccess value");
  end

  typedef enum logic {
    StIdle,
    StStaged
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] committed;
  logic [DW-1:0] shadow;
  logic [DW-1:0] staged;
  logic [DW-1:0] cand;
  logic          stage_en;
  logic          commit;
  logic          upd_err;

  // Candidate value the software write would produce given the current committed value.
  always_comb begin
    cand = wd;
    unique case (SwAccess)
      SwAccessW1C: cand = committed & ~wd;
      SwAccessW1S: cand = committed | wd;
      SwAccessW0C: cand = committed & wd;
      default:     cand = wd;
    endcase
  end

  // Two-write staging FSM: first write stages, second write commits or flags a mismatch.
  always_comb begin
    state_d  = state_q;
    stage_en = 1'b0;
    commit   = 1'b0;
    upd_err  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (we) begin
          stage_en = 1'b1;
          state_d  = StStaged;
        end
      end
      StStaged: begin
        // A write takes priority over a read in the same cycle.
        if (we) begin
          state_d = StIdle;
          if (cand == staged) commit  = 1'b1;
          else                upd_err = 1'b1;
        end else if (re) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Hardware data wins over a simultaneous software commit.
  assign qe    = de | commit;
  assign ds    = de ? d : (commit ? cand : committed);
  assign q     = committed;
  assign qs    = committed;
  assign phase = (state_q == StStaged);

  // State, staged copy, committed/shadow pair and registered error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      staged      <= RESVAL;
      committed   <= RESVAL;
      shadow      <= ~RESVAL;
      err_update  <= 1'b0;
      err_storage <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_update <= upd_err;
      if (stage_en) staged <= cand;
      if (qe) begin
        committed <= ds;
        shadow    <= ~ds;
      end
      // Sticky: once the pair disagrees, only reset clears the flag.
      err_storage <= err_storage | (committed != ~shadow);
    end
  end

endmodule

// File: tb/tb_abr_prim_subreg_shadow.sv
// Directed bench for the shadowed register slice: an RW instance and a W1C instance.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// Each check is an immediate assertion that counts and reports miscompares.
module tb_abr_prim_subreg_shadow;
  import abr_prim_subreg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // RW instance, 32 bits, reset value 0
  logic        rst, re, we, de;
  logic [31:0] wd, d;
  logic        qe, phase, err_update, err_storage;
  logic [31:0] q, qs, ds;

  // W1C instance, 8 bits, reset value 0xFF
  logic        w_re, w_we, w_de;
  logic [7:0]  w_wd, w_d;
  logic        w_qe, w_phase, w_err_update, w_err_storage;
  logic [7:0]  w_q, w_qs, w_ds;

  abr_prim_subreg_shadow #(.DW(32), .SwAccess(SwAccessRW), .RESVAL(32'h0)) u_rw (
    .clk_i(clk), .rst_i(rst), .re(re), .we(we), .wd(wd), .de(de), .d(d),
    .qe(qe), .q(q), .qs(qs), .ds(ds), .phase(phase),
    .err_update(err_update), .err_storage(err_storage)
  );

  abr_prim_subreg_shadow #(.DW(8), .SwAccess(SwAccessW1C), .RESVAL(8'hFF)) u_w1c (
    .clk_i(clk), .rst_i(rst), .re(w_re), .we(w_we), .wd(w_wd), .de(w_de), .d(w_d),
    .qe(w_qe), .q(w_q), .qs(w_qs), .ds(w_ds), .phase(w_phase),
    .err_update(w_err_update), .err_storage(w_err_storage)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; de = 1'b0; wd = '0; d = '0;
    w_re = 1'b0; w_we = 1'b0; w_de = 1'b0; w_wd = '0; w_d = '0;
    adv; adv;
    rst = 1'b0;
    settle;

    // Reset state
    chk("rst_q",          q, 32'h0);
    chk("rst_qs",         qs, 32'h0);
    chk("rst_phase",      32'(phase), 32'h0);
    chk("rst_qe",         32'(qe), 32'h0);
    chk("rst_err_upd",    32'(err_update), 32'h0);
    chk("rst_err_sto",    32'(err_storage), 32'h0);
    chk("rst_w1c_q",      32'(w_q), 32'hFF);

    // Matching write pair commits
    we = 1'b1; wd = 32'hA5A5_0001;
    settle;
    chk("t1_first_qe",    32'(qe), 32'h0);
    chk("t1_first_ds",    ds, 32'h0);
    adv;
    settle;
    chk("t1_staged_phase", 32'(phase), 32'h1);
    chk("t1_staged_q",    q, 32'h0);
    chk("t1_second_qe",   32'(qe), 32'h1);
    chk("t1_second_ds",   ds, 32'hA5A5_0001);
    adv;
    we = 1'b0;
    settle;
    chk("t1_commit_q",    q, 32'hA5A5_0001);
    chk("t1_commit_qs",   qs, 32'hA5A5_0001);
    chk("t1_commit_phase", 32'(phase), 32'h0);
    chk("t1_commit_err",  32'(err_update), 32'h0);

    // Mismatching pair: no commit, one-cycle update error
    we = 1'b1; wd = 32'h1234;
    adv;
    wd = 32'h1235;
    settle;
    chk("t2_mis_qe",      32'(qe), 32'h0);
    adv;
    we = 1'b0;
    settle;
    chk("t2_err_pulse",   32'(err_update), 32'h1);
    chk("t2_q_kept",      q, 32'hA5A5_0001);
    chk("t2_phase",       32'(phase), 32'h0);
    adv;
    chk("t2_err_gone",    32'(err_update), 32'h0);
    we = 1'b1; wd = 32'h55;
    adv; adv;
    we = 1'b0;
    settle;
    chk("t2_recommit_q",  q, 32'h55);

    // W1C: read aborts staging, then a pair clears the written ones
    w_we = 1'b1; w_wd = 8'h0F;
    adv;
    w_we = 1'b0; w_re = 1'b1;
    settle;
    chk("t3_staged",      32'(w_phase), 32'h1);
    adv;
    w_re = 1'b0;
    settle;
    chk("t3_abort_phase", 32'(w_phase), 32'h0);
    chk("t3_abort_q",     32'(w_q), 32'hFF);
    w_we = 1'b1; w_wd = 8'h0F;
    adv;
    settle;
    chk("t3_commit_qe",   32'(w_qe), 32'h1);
    chk("t3_commit_ds",   32'(w_ds), 32'hF0);
    adv;
    w_we = 1'b0;
    settle;
    chk("t3_commit_q",    32'(w_q), 32'hF0);

    // Hardware write collides with a software commit: hardware wins, no error
    we = 1'b1; wd = 32'h10;
    adv;
    de = 1'b1; d = 32'h77;
    settle;
    chk("t4_qe",          32'(qe), 32'h1);
    chk("t4_ds",          ds, 32'h77);
    adv;
    we = 1'b0; de = 1'b0;
    settle;
    chk("t4_q",           q, 32'h77);
    chk("t4_phase",       32'(phase), 32'h0);
    chk("t4_err_upd",     32'(err_update), 32'h0);

    // Storage fault: corrupt shadow so it no longer mirrors q
    we = 1'b1; wd = 32'h3C;
    adv; adv;
    we = 1'b0;
    settle;
    chk("t5_q",           q, 32'h3C);
    chk("t5_no_err",      32'(err_storage), 32'h0);
    force u_rw.shadow = 32'h3C;
    adv;
    release u_rw.shadow;
    chk("t5_err_set",     32'(err_storage), 32'h1);
    we = 1'b1; wd = 32'h66;
    adv; adv;
    we = 1'b0;
    settle;
    chk("t5_q_after",     q, 32'h66);
    chk("t5_err_sticky",  32'(err_storage), 32'h1);
    adv;
    chk("t5_err_sticky2", 32'(err_storage), 32'h1);

    // Reset mid-staging discards the staged value
    we = 1'b1; wd = 32'hAB;
    adv;
    we = 1'b0;
    settle;
    chk("t6_staged",      32'(phase), 32'h1);
    rst = 1'b1;
    adv;
    rst = 1'b0;
    settle;
    chk("t6_rst_q",       q, 32'h0);
    chk("t6_rst_phase",   32'(phase), 32'h0);
    chk("t6_rst_err_sto", 32'(err_storage), 32'h0);
    chk("t6_rst_err_upd", 32'(err_update), 32'h0);
    we = 1'b1; wd = 32'hAB;
    settle;
    chk("t6_single_qe",   32'(qe), 32'h0);
    adv;
    we = 1'b0;
    settle;
    chk("t6_single_q",    q, 32'h0);
    chk("t6_single_phase", 32'(phase), 32'h1);

    // Hardware update while staged leaves the staging phase intact
    de = 1'b1; d = 32'h5;
    adv;
    de = 1'b0;
    settle;
    chk("t7_hw_q",        q, 32'h5);
    chk("t7_hw_phase",    32'(phase), 32'h1);
    we = 1'b1; wd = 32'hAB;
    adv;
    we = 1'b0;
    settle;
    chk("t7_commit_q",    q, 32'hAB);
    chk("t7_err_sto",     32'(err_storage), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
